// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load extraction/extension, writeback select, retire count, misaligned-load flag.
// Latency: 1 cycle, every output is registered; no combinational input-to-output path.
// Backpressure: Stall freezes every WB register (count included); Flush beats Stall and loads a bubble.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              ValidM,
  input  logic [DATA_W-1:0] MemoryReadData,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] PCPlus8M,
  input  logic              RegWriteM,
  input  logic              MemToRegM,
  input  logic              LinkM,
  input  logic [1:0]        LoadSizeM,
  input  logic              LoadUnsignedM,
  input  logic [REG_AW-1:0] WriteRegM,
  output logic [DATA_W-1:0] WriteDataW,
  output logic [REG_AW-1:0] WriteRegW,
  output logic              RegWriteW,
  output logic              ValidW,
  output logic              AlignErrW,
  output logic [31:0]       RetireCount
);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_ext;
  logic              misaligned;
  logic [DATA_W-1:0] wb_data;
  logic              reg_write_next;
  logic              align_err_next;
  logic [31:0]       retire_count;

  assign RetireCount = retire_count;

  // Little-endian lane pick: byte by addr[1:0], halfword by addr[1] (addr[0] ignored).
  always_comb begin
    byte_sel = MemoryReadData[7:0];
    case (ALUResultM[1:0])
      2'd0: byte_sel = MemoryReadData[7:0];
      2'd1: byte_sel = MemoryReadData[15:8];
      2'd2: byte_sel = MemoryReadData[23:16];
      2'd3: byte_sel = MemoryReadData[31:24];
      default: byte_sel = MemoryReadData[7:0];
    endcase
    half_sel = ALUResultM[1] ? MemoryReadData[31:16] : MemoryReadData[15:0];
  end

  // Sign/zero extension; the reserved size code behaves as a full word.
  always_comb begin
    load_ext = MemoryReadData;
    case (LoadSizeM)
      SZ_HALF: load_ext = LoadUnsignedM ? {{(DATA_W-16){1'b0}}, half_sel}
                                        : {{(DATA_W-16){half_sel[15]}}, half_sel};
      SZ_BYTE: load_ext = LoadUnsignedM ? {{(DATA_W-8){1'b0}}, byte_sel}
                                        : {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      default: load_ext = MemoryReadData;
    endcase
  end

  // Misalignment only matters for real loads; link writes never fault.
  always_comb begin
    misaligned = 1'b0;
    if (MemToRegM && !LinkM) begin
      case (LoadSizeM)
        SZ_HALF: misaligned = ALUResultM[0];
        SZ_BYTE: misaligned = 1'b0;
        SZ_WORD: misaligned = (ALUResultM[1:0] != 2'b00);
        default: misaligned = (ALUResultM[1:0] != 2'b00);
      endcase
    end
  end

  // Writeback source select and write-enable qualification ($0 never written).
  always_comb begin
    if (LinkM)          wb_data = PCPlus8M;
    else if (MemToRegM) wb_data = load_ext;
    else                wb_data = ALUResultM;
    reg_write_next = RegWriteM & ValidM & ~misaligned & (WriteRegM != '0);
    align_err_next = ValidM & misaligned;
  end

  // WB boundary registers: Flush > Stall > capture; counter only moves on a valid capture.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      WriteDataW   <= '0;
      WriteRegW    <= '0;
      RegWriteW    <= 1'b0;
      ValidW       <= 1'b0;
      AlignErrW    <= 1'b0;
      retire_count <= '0;
    end else if (Flush) begin
      WriteDataW   <= '0;
      WriteRegW    <= '0;
      RegWriteW    <= 1'b0;
      ValidW       <= 1'b0;
      AlignErrW    <= 1'b0;
    end else if (!Stall) begin
      WriteDataW   <= wb_data;
      WriteRegW    <= WriteRegM;
      RegWriteW    <= reg_write_next;
      ValidW       <= ValidM;
      AlignErrW    <= align_err_next;
      if (ValidM) retire_count <= retire_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed vectors with hand-computed results.
// The driver queues the expected WB state for each edge; a monitor checks it 1ns after the edge.
module tb_mem_wb_stage;

  logic        Clk;
  logic        Rst_n;
  logic        Stall, Flush, ValidM;
  logic [31:0] MemoryReadData, ALUResultM, PCPlus8M;
  logic        RegWriteM, MemToRegM, LinkM, LoadUnsignedM;
  logic [1:0]  LoadSizeM;
  logic [4:0]  WriteRegM;
  logic [31:0] WriteDataW;
  logic [4:0]  WriteRegW;
  logic        RegWriteW, ValidW, AlignErrW;
  logic [31:0] RetireCount;

  mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush), .ValidM(ValidM),
    .MemoryReadData(MemoryReadData), .ALUResultM(ALUResultM), .PCPlus8M(PCPlus8M),
    .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .LinkM(LinkM),
    .LoadSizeM(LoadSizeM), .LoadUnsignedM(LoadUnsignedM), .WriteRegM(WriteRegM),
    .WriteDataW(WriteDataW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .ValidW(ValidW), .AlignErrW(AlignErrW), .RetireCount(RetireCount)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        regw;
    logic        valid;
    logic        aerr;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last;
  logic [31:0] model_cnt;
  int          checks = 0;
  int          errors = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  task automatic check_all_zero(input string nm);
    cmp({nm, " WriteDataW"}, WriteDataW, 32'h0);
    cmp({nm, " WriteRegW"}, {27'h0, WriteRegW}, 32'h0);
    cmp({nm, " RegWriteW"}, {31'h0, RegWriteW}, 32'h0);
    cmp({nm, " ValidW"}, {31'h0, ValidW}, 32'h0);
    cmp({nm, " AlignErrW"}, {31'h0, AlignErrW}, 32'h0);
    cmp({nm, " RetireCount"}, RetireCount, 32'h0);
  endtask

  // Monitor: the WB registers present a new result after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp({e.name, " WriteDataW"}, WriteDataW, e.data);
        cmp({e.name, " WriteRegW"}, {27'h0, WriteRegW}, {27'h0, e.rd});
        cmp({e.name, " RegWriteW"}, {31'h0, RegWriteW}, {31'h0, e.regw});
        cmp({e.name, " ValidW"}, {31'h0, ValidW}, {31'h0, e.valid});
        cmp({e.name, " AlignErrW"}, {31'h0, AlignErrW}, {31'h0, e.aerr});
        cmp({e.name, " RetireCount"}, RetireCount, e.cnt);
      end
    end
  end

  // Drive one cycle of inputs and queue the state WB must hold after the next edge.
  task automatic issue(input string nm, input logic stl, input logic fls, input logic vld,
                       input logic [31:0] rdata, input logic [31:0] alu, input logic [31:0] pc8,
                       input logic rw, input logic m2r, input logic lnk, input logic [1:0] sz,
                       input logic uns, input logic [4:0] wr,
                       input logic [31:0] e_data, input logic e_regw, input logic e_aerr);
    exp_t e;
    Stall = stl; Flush = fls; ValidM = vld;
    MemoryReadData = rdata; ALUResultM = alu; PCPlus8M = pc8;
    RegWriteM = rw; MemToRegM = m2r; LinkM = lnk; LoadSizeM = sz;
    LoadUnsignedM = uns; WriteRegM = wr;
    e.name = nm;
    if (fls) begin
      e.data = 32'h0; e.rd = 5'd0; e.regw = 1'b0; e.valid = 1'b0; e.aerr = 1'b0;
      e.cnt = model_cnt;
    end else if (stl) begin
      e = last;
      e.name = nm;
    end else begin
      if (vld) model_cnt = model_cnt + 32'd1;
      e.data = e_data; e.rd = wr; e.regw = e_regw; e.valid = vld; e.aerr = e_aerr;
      e.cnt = model_cnt;
    end
    last = e;
    sb_q.push_back(e);
    @(posedge Clk);
    #2;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 20) begin
      @(posedge Clk);
      #2;
      n++;
    end
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
  endtask

  localparam logic [31:0] W = 32'h1234_80FF;

  initial begin
    Rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0; ValidM = 1'b0;
    MemoryReadData = 32'h0; ALUResultM = 32'h0; PCPlus8M = 32'h0;
    RegWriteM = 1'b0; MemToRegM = 1'b0; LinkM = 1'b0; LoadSizeM = 2'b00;
    LoadUnsignedM = 1'b0; WriteRegM = 5'd0;
    model_cnt = 32'h0;
    last = '{"init", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0};
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #2;

    //     name       stl   fls   vld   rdata          alu           pc8            rw    m2r   lnk   sz     uns   wr     exp data       regw  aerr
    issue("lw",       1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h100,      32'h0,         1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 5'd8,  32'hDEADBEEF, 1'b1, 1'b0);
    issue("lb101",    1'b0, 1'b0, 1'b1, W,            32'h101,      32'h0,         1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 5'd9,  32'hFFFFFF80, 1'b1, 1'b0);
    issue("lbu101",   1'b0, 1'b0, 1'b1, W,            32'h101,      32'h0,         1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 5'd10, 32'h00000080, 1'b1, 1'b0);
    issue("lh102",    1'b0, 1'b0, 1'b1, W,            32'h102,      32'h0,         1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 5'd11, 32'h00001234, 1'b1, 1'b0);
    issue("lhu100",   1'b0, 1'b0, 1'b1, W,            32'h100,      32'h0,         1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 5'd12, 32'h000080FF, 1'b1, 1'b0);
    issue("lh100",    1'b0, 1'b0, 1'b1, W,            32'h100,      32'h0,         1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 5'd13, 32'hFFFF80FF, 1'b1, 1'b0);
    issue("lb103",    1'b0, 1'b0, 1'b1, W,            32'h103,      32'h0,         1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 5'd14, 32'h00000012, 1'b1, 1'b0);
    issue("lb100",    1'b0, 1'b0, 1'b1, W,            32'h100,      32'h0,         1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 5'd15, 32'hFFFFFFFF, 1'b1, 1'b0);
    issue("lwmis",    1'b0, 1'b0, 1'b1, W,            32'h102,      32'h0,         1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 5'd16, W,            1'b0, 1'b1);
    issue("add",      1'b0, 1'b0, 1'b1, W,            32'h55,       32'h0,         1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd3,  32'h00000055, 1'b1, 1'b0);
    issue("stall1",   1'b1, 1'b0, 1'b1, 32'h1111,     32'hAAAA0000, 32'h0,         1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd4,  32'h0,        1'b0, 1'b0);
    issue("stall2",   1'b1, 1'b0, 1'b1, 32'h2222,     32'h102,      32'h0,         1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 5'd5,  32'h0,        1'b0, 1'b0);
    issue("stall3",   1'b1, 1'b0, 1'b0, 32'h3333,     32'hBBBB0000, 32'h0,         1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd6,  32'h0,        1'b0, 1'b0);
    issue("lhmis",    1'b0, 1'b0, 1'b1, W,            32'h101,      32'h0,         1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 5'd17, 32'hFFFF80FF, 1'b0, 1'b1);
    issue("stallmis", 1'b1, 1'b0, 1'b1, W,            32'h100,      32'h0,         1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd18, 32'h0,        1'b0, 1'b0);
    issue("stlflush", 1'b1, 1'b1, 1'b1, W,            32'h100,      32'h0,         1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd19, 32'h0,        1'b0, 1'b0);
    issue("jal",      1'b0, 1'b0, 1'b1, W,            32'h103,      32'h00400010,  1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 5'd31, 32'h00400010, 1'b1, 1'b0);
    issue("wr0",      1'b0, 1'b0, 1'b1, W,            32'h77,       32'h0,         1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0,  32'h00000077, 1'b0, 1'b0);
    issue("bubble",   1'b0, 1'b0, 1'b0, W,            32'h88,       32'h0,         1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd7,  32'h00000088, 1'b0, 1'b0);
    issue("rsvd",     1'b0, 1'b0, 1'b1, W,            32'h100,      32'h0,         1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 5'd20, W,            1'b1, 1'b0);
    issue("flush",    1'b0, 1'b1, 1'b1, W,            32'h100,      32'h0,         1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 5'd21, 32'h0,        1'b0, 1'b0);
    drain();

    // Counter wrap: preload the count just below the top, then two valid captures.
    force dut.retire_count = 32'hFFFF_FFFE;
    #1;
    release dut.retire_count;
    model_cnt = 32'hFFFF_FFFE;
    cmp("preload RetireCount", RetireCount, 32'hFFFF_FFFE);
    issue("wrap1",    1'b0, 1'b0, 1'b1, 32'h0,        32'h10,       32'h0,         1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd1,  32'h00000010, 1'b1, 1'b0);
    issue("wrap2",    1'b0, 1'b0, 1'b1, 32'h0,        32'h20,       32'h0,         1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd2,  32'h00000020, 1'b1, 1'b0);
    issue("pre_rst",  1'b1, 1'b0, 1'b1, 32'h0,        32'h30,       32'h0,         1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd2,  32'h0,        1'b0, 1'b0);
    drain();

    // Asynchronous reset mid-cycle while stalled: outputs must clear before the next edge.
    Rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge Clk);
    Rst_n = 1'b1;
    Stall = 1'b0;
    ValidM = 1'b0;
    #1;
    check_all_zero("postreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline stage directly downstream of the Memory stage: registers the Memory-stage results into the MEM/WB boundary.
- Performs load sub-word extraction and sign/zero extension, and selects the writeback source (ALU, load data or link address).
- Drives the register-file write port and the WriteDataD forwarding path back into the Memory stage.
- Counts retired instructions and flags misaligned loads.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_AW, 5, register-file address width.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous, active-low reset.
- Stall  input  1  hold all WB registers (hazard unit).
- Flush  input  1  load a bubble into WB on the next edge.
- ValidM  input  1  Memory stage holds a real instruction.
- MemoryReadData  input  32  raw word from data memory (same cycle as MemoryAddress).
- ALUResultM  input  32  ALU result / memory address from the Memory stage.
- PCPlus8M  input  32  link address for JAL/JALR.
- RegWriteM  input  1  instruction writes the register file.
- MemToRegM  input  1  writeback source is load data.
- LinkM  input  1  writeback source is PCPlus8M (overrides MemToRegM).
- LoadSizeM  input  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
- LoadUnsignedM  input  1  zero-extend sub-word loads.
- WriteRegM  input  5  destination register.
- WriteDataW  output  32  registered writeback value; also the WriteDataD forwarding source.
- WriteRegW  output  5  registered destination.
- RegWriteW  output  1  registered register-file write enable.
- ValidW  output  1  WB holds a real instruction.
- AlignErrW  output  1  misaligned load retired this cycle.
- RetireCount  output  32  number of valid instructions that have entered WB.

Behaviour:
- Reset (Rst_n low, asynchronous): all outputs go to 0 immediately and stay 0 until the first rising edge after deassertion. This covers WriteDataW, WriteRegW, RegWriteW, ValidW, AlignErrW and RetireCount.
- Latency: exactly 1 cycle. Inputs sampled on edge N appear on the outputs after edge N. No combinational path from inputs to outputs.
- Edge priority is Flush > Stall > normal capture.
  - Flush: ValidW=0, RegWriteW=0, WriteRegW=0, WriteDataW=0, AlignErrW=0; RetireCount unchanged.
  - Stall (without Flush): every register holds, including RetireCount. AlignErrW holds its value.
  - Normal: capture the computed values below.
- Load extraction uses byte lane = ALUResultM[1:0], little-endian.
  - Byte: lane k selects MemoryReadData[8k+7:8k].
  - Halfword: ALUResultM[1] selects the upper or lower 16 bits.
  - Word: the full word.
  - Extension: sign-extend from bit 7 or bit 15 unless LoadUnsignedM, in which case zero-extend.
- Misalignment applies only when MemToRegM=1 and LinkM=0.
  - Condition: halfword with ALUResultM[0]=1, or word/reserved with ALUResultM[1:0]≠0.
  - Result: AlignErrW=1 and RegWriteW=0; WriteDataW still captures the extracted value (lane rules applied, unaligned bits ignored).
- Writeback mux: LinkM → PCPlus8M; else MemToRegM → extracted load; else ALUResultM.
- RegWriteW = RegWriteM & ValidM & ~misaligned & (WriteRegM≠0). Writes to $0 are always suppressed.
- ValidW = ValidM on a normal capture.
- RetireCount increments by 1 on every normal capture with ValidM=1, including misaligned loads. It wraps from 0xFFFFFFFF to 0.
- AlignErrW is a registered flag valid only while the offending instruction is in WB; it clears on the next normal capture or Flush.
- Reset asserted mid-stall clears everything; the stalled instruction is lost.

Test Plan:
- Reset release, then lw with MemoryReadData=0xDEADBEEF, ALUResultM=0x100, WriteRegM=8 → one cycle later WriteDataW=0xDEADBEEF, WriteRegW=8, RegWriteW=1, ValidW=1, RetireCount=1.
- lb on word 0x1234_80FF: addr 0x101 → 0xFFFFFF80; lbu → 0x00000080; lh at addr 0x102 → 0x00001234; lhu at addr 0x100 → 0x000080FF.
- lw at addr 0x102 → AlignErrW=1, RegWriteW=0, ValidW=1, RetireCount increments. Next capture clears AlignErrW.
- Stall held for 3 cycles with changing inputs → outputs and RetireCount frozen. Stall and Flush together → bubble (RegWriteW=0, ValidW=0).
- jal with LinkM=1, PCPlus8M=0x0040_0010, WriteRegM=31 → WriteDataW=0x00400010, RegWriteW=1. Any write with WriteRegM=0 → RegWriteW=0.
- Preload 0xFFFFFFFE retirements via force, then 2 valid captures → RetireCount=0. Assert Rst_n low mid-cycle → all outputs 0 before the next edge.
